led_pattern_ctrl: RTL

- Multi-channel LED pattern generator; parametrised successor to the single free-running blink counter.
- Each output channel is independently programmable as OFF, ON, BLINK (programmable half-period) or PWM (programmable duty).
- Sits between board-control logic (config writer) and the board LED pins `pio_led`.
- Configured through a valid/ready write port, one channel per transfer.

---
 rtl/led_pattern_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: multi-channel LED pattern generator (OFF / ON / BLINK / PWM).
// Writes arrive one channel per valid/ready transfer; the accept edge is followed
// by a commit cycle that loads the channel, so ready drops for one cycle per write.
// Optional build macro LED_BREATHE_EN: PWM mode ramps its effective duty up and
// down between 0 and the programmed duty, one step per PWM counter wrap.
module led_pattern_ctrl #(
  parameter int N_LED = 4,
  parameter int CNT_W = 27,
  parameter int PWM_W = 8,
  parameter int CH_W  = (N_LED > 1) ? $clog2(N_LED) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [CH_W-1:0]  cfg_ch_i,
  input  logic [1:0]       cfg_mode_i,
  input  logic [CNT_W-1:0] cfg_period_i,
  input  logic [PWM_W-1:0] cfg_duty_i,
  output logic             cfg_err_o,
  output logic [N_LED-1:0] pio_led_o
);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_PWM   = 2'd3;

  localparam logic [CH_W:0] N_LED_C = (CH_W+1)'(N_LED);

  // handshake / pending write
  logic             ready_q, ready_d;
  logic             commit_q, commit_d;
  logic             err_q, err_d;
  logic [CH_W-1:0]  wr_ch_q, wr_ch_d;
  logic [1:0]       wr_mode_q, wr_mode_d;
  logic [CNT_W-1:0] wr_period_q, wr_period_d;
  logic [PWM_W-1:0] wr_duty_q, wr_duty_d;

  // per-channel state
  logic [1:0]       mode_q   [N_LED];
  logic [1:0]       mode_d   [N_LED];
  logic [CNT_W-1:0] period_q [N_LED];
  logic [CNT_W-1:0] period_d [N_LED];
  logic [PWM_W-1:0] duty_q   [N_LED];
  logic [PWM_W-1:0] duty_d   [N_LED];
  logic [CNT_W-1:0] bcnt_q   [N_LED];
  logic [CNT_W-1:0] bcnt_d   [N_LED];
  logic [N_LED-1:0] phase_q, phase_d;
  logic [N_LED-1:0] pio_q, pio_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

`ifdef LED_BREATHE_EN
  logic [PWM_W-1:0] ramp_q [N_LED];
  logic [PWM_W-1:0] ramp_d [N_LED];
  logic [N_LED-1:0] down_q, down_d;
`endif

  logic accept;
  logic pwm_wrap;

  assign accept      = cfg_valid_i && ready_q;
  assign pwm_wrap    = &pwm_cnt_q;
  assign cfg_ready_o = ready_q;
  assign cfg_err_o   = err_q;
  assign pio_led_o   = pio_q;

  // Terminal count of the blink half-period; period 0 acts as period 1.
  function automatic logic blink_tc(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] per);
    logic [CNT_W-1:0] lim_m1;
    lim_m1 = (per == '0) ? '0 : per - 1'b1;
    return cnt == lim_m1;
  endfunction

  // Handshake: ready drops for the commit cycle after every accepted write.
  always_comb begin
    ready_d     = !accept;
    commit_d    = accept && ({1'b0, cfg_ch_i} < N_LED_C);
    err_d       = accept && !({1'b0, cfg_ch_i} < N_LED_C);
    wr_ch_d     = accept ? cfg_ch_i     : wr_ch_q;
    wr_mode_d   = accept ? cfg_mode_i   : wr_mode_q;
    wr_period_d = accept ? cfg_period_i : wr_period_q;
    wr_duty_d   = accept ? cfg_duty_i   : wr_duty_q;
  end

  // Per-channel next state: commit load, blink counting, output pattern.
  always_comb begin
    mode_d    = mode_q;
    period_d  = period_q;
    duty_d    = duty_q;
    bcnt_d    = bcnt_q;
    phase_d   = phase_q;
    pio_d     = '0;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
`ifdef LED_BREATHE_EN
    ramp_d    = ramp_q;
    down_d    = down_q;
`endif
    for (int i = 0; i < N_LED; i++) begin
      logic [PWM_W-1:0] eff_duty;
`ifdef LED_BREATHE_EN
      eff_duty = ramp_q[i];
`else
      eff_duty = duty_q[i];
`endif
      case (mode_q[i])
        MODE_ON:    pio_d[i] = 1'b1;
        MODE_BLINK: pio_d[i] = phase_q[i];
        MODE_PWM:   pio_d[i] = pwm_cnt_q < eff_duty;
        default:    pio_d[i] = 1'b0;
      endcase

      if (commit_q && (wr_ch_q == CH_W'(i))) begin
        mode_d[i]   = wr_mode_q;
        period_d[i] = wr_period_q;
        duty_d[i]   = wr_duty_q;
        bcnt_d[i]   = '0;
        phase_d[i]  = 1'b1;
`ifdef LED_BREATHE_EN
        ramp_d[i]   = '0;
        down_d[i]   = 1'b0;
`endif
      end else begin
        if (mode_q[i] == MODE_BLINK) begin
          if (blink_tc(bcnt_q[i], period_q[i])) begin
            bcnt_d[i]  = '0;
            phase_d[i] = !phase_q[i];
          end else begin
            bcnt_d[i]  = bcnt_q[i] + 1'b1;
          end
        end else begin
          bcnt_d[i] = '0;
        end
`ifdef LED_BREATHE_EN
        // Triangle ramp 0..duty..0, one step per PWM period.
        if (mode_q[i] == MODE_PWM && pwm_wrap && duty_q[i] != '0) begin
          if (!down_q[i]) begin
            if (ramp_q[i] < duty_q[i]) begin
              ramp_d[i] = ramp_q[i] + 1'b1;
            end else begin
              ramp_d[i] = ramp_q[i] - 1'b1;
              down_d[i] = 1'b1;
            end
          end else if (ramp_q[i] != '0) begin
            ramp_d[i] = ramp_q[i] - 1'b1;
          end else begin
            ramp_d[i] = ramp_q[i] + 1'b1;
            down_d[i] = 1'b0;
          end
        end
`endif
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q     <= 1'b0;
      commit_q    <= 1'b0;
      err_q       <= 1'b0;
      wr_ch_q     <= '0;
      wr_mode_q   <= MODE_OFF;
      wr_period_q <= '0;
      wr_duty_q   <= '0;
      phase_q     <= '1;
      pio_q       <= '0;
      pwm_cnt_q   <= '0;
      for (int i = 0; i < N_LED; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= '0;
        duty_q[i]   <= '0;
        bcnt_q[i]   <= '0;
`ifdef LED_BREATHE_EN
        ramp_q[i]   <= '0;
`endif
      end
`ifdef LED_BREATHE_EN
      down_q      <= '0;
`endif
    end else begin
      ready_q     <= ready_d;
      commit_q    <= commit_d;
      err_q       <= err_d;
      wr_ch_q     <= wr_ch_d;
      wr_mode_q   <= wr_mode_d;
      wr_period_q <= wr_period_d;
      wr_duty_q   <= wr_duty_d;
      phase_q     <= phase_d;
      pio_q       <= pio_d;
      pwm_cnt_q   <= pwm_cnt_d;
      mode_q      <= mode_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      bcnt_q      <= bcnt_d;
`ifdef LED_BREATHE_EN
      ramp_q      <= ramp_d;
      down_q      <= down_d;
`endif
    end
  end

endmodule
